// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter feeding a 1-entry registered CDB stage.
// Stale-epoch results are consumed and counted, never buffered.
module wb_arbiter #(
    parameter  int NUM_SRC = 4,
    localparam int ROB_W   = 6,
    localparam int PHYS_W  = 7,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*32-1:0]     src_pc,
    input  logic [NUM_SRC*ROB_W-1:0]  src_rob_idx,
    input  logic [NUM_SRC*PHYS_W-1:0] src_prd_new,
    input  logic [NUM_SRC*2-1:0]      src_epoch,
    input  logic [NUM_SRC*32-1:0]     src_data,
    input  logic [1:0]                cur_epoch,
    input  logic                      flush,
    output logic                      cdb_valid,
    input  logic                      cdb_ready,
    output logic [31:0]               cdb_pc,
    output logic [ROB_W-1:0]          cdb_rob_idx,
    output logic [PHYS_W-1:0]         cdb_prd_new,
    output logic [1:0]                cdb_epoch,
    output logic [31:0]               cdb_data,
    output logic [IDX_W-1:0]          cdb_grant_id,
    output logic [15:0]               drop_cnt
);

    logic              out_vld_q, out_vld_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]       pc_q, pc_d;
    logic [ROB_W-1:0]  rob_q, rob_d;
    logic [PHYS_W-1:0] prd_q, prd_d;
    logic [1:0]        epoch_q, epoch_d;
    logic [31:0]       data_q, data_d;
    logic [IDX_W-1:0]  gid_q, gid_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [NUM_SRC-1:0] stale, elig, grant;
    logic               out_free, found;
    logic [IDX_W-1:0]   gnt_idx, scan_idx;
    logic [IDX_W:0]     scan_sum;
    logic [4:0]         drop_n;
    logic [16:0]        drop_sum;

    always_comb begin
        stale = '0;
        elig  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            stale[i] = src_valid[i] && (src_epoch[2*i +: 2] != cur_epoch);
            elig[i]  = src_valid[i] && !stale[i];
        end

        out_free = !out_vld_q || (cdb_ready && !flush);

        // Scan from rr_ptr upward with wrap; first eligible wins.
        grant    = '0;
        found    = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        if (out_free && !flush && !rst) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                if (scan_sum >= (IDX_W+1)'(NUM_SRC))
                    scan_sum = scan_sum - (IDX_W+1)'(NUM_SRC);
                scan_idx = scan_sum[IDX_W-1:0];
                if (!found && elig[scan_idx]) begin
                    found           = 1'b1;
                    grant[scan_idx] = 1'b1;
                    gnt_idx         = scan_idx;
                end
            end
        end

        src_ready = (stale | grant) & {NUM_SRC{!flush && !rst}};

        out_vld_d = out_vld_q && !cdb_ready && !flush;
        rr_ptr_d  = rr_ptr_q;
        pc_d      = pc_q;
        rob_d     = rob_q;
        prd_d     = prd_q;
        epoch_d   = epoch_q;
        data_d    = data_q;
        gid_d     = gid_q;
        if (found) begin
            out_vld_d = 1'b1;
            rr_ptr_d  = (gnt_idx == IDX_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
            pc_d      = src_pc[gnt_idx*32 +: 32];
            rob_d     = src_rob_idx[gnt_idx*ROB_W +: ROB_W];
            prd_d     = src_prd_new[gnt_idx*PHYS_W +: PHYS_W];
            epoch_d   = src_epoch[gnt_idx*2 +: 2];
            data_d    = src_data[gnt_idx*32 +: 32];
            gid_d     = gnt_idx;
        end

        drop_n = '0;
        for (int i = 0; i < NUM_SRC; i++)
            drop_n = drop_n + 5'(stale[i] && !flush);
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_n);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            rr_ptr_q   <= '0;
            pc_q       <= '0;
            rob_q      <= '0;
            prd_q      <= '0;
            epoch_q    <= '0;
            data_q     <= '0;
            gid_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            rr_ptr_q   <= rr_ptr_d;
            pc_q       <= pc_d;
            rob_q      <= rob_d;
            prd_q      <= prd_d;
            epoch_q    <= epoch_d;
            data_q     <= data_d;
            gid_q      <= gid_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign cdb_valid    = out_vld_q && !flush;
    assign cdb_pc       = pc_q;
    assign cdb_rob_idx  = rob_q;
    assign cdb_prd_new  = prd_q;
    assign cdb_epoch    = epoch_q;
    assign cdb_data     = data_q;
    assign cdb_grant_id = gid_q;
    assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed-vector bench for wb_arbiter: grant order, backpressure,
// stale drops with saturation, flush and mid-run reset.
module tb_wb_arbiter;

    localparam int NUM_SRC = 4;
    localparam int ROB_W   = 6;
    localparam int PHYS_W  = 7;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC*32-1:0]     src_pc;
    logic [NUM_SRC*ROB_W-1:0]  src_rob_idx;
    logic [NUM_SRC*PHYS_W-1:0] src_prd_new;
    logic [NUM_SRC*2-1:0]      src_epoch;
    logic [NUM_SRC*32-1:0]     src_data;
    logic [1:0]                cur_epoch;
    logic                      flush;
    logic                      cdb_valid;
    logic                      cdb_ready;
    logic [31:0]               cdb_pc;
    logic [ROB_W-1:0]          cdb_rob_idx;
    logic [PHYS_W-1:0]         cdb_prd_new;
    logic [1:0]                cdb_epoch;
    logic [31:0]               cdb_data;
    logic [1:0]                cdb_grant_id;
    logic [15:0]               drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    wb_arbiter #(.NUM_SRC(NUM_SRC)) dut (
        .clk          (clk),
        .rst          (rst),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_pc       (src_pc),
        .src_rob_idx  (src_rob_idx),
        .src_prd_new  (src_prd_new),
        .src_epoch    (src_epoch),
        .src_data     (src_data),
        .cur_epoch    (cur_epoch),
        .flush        (flush),
        .cdb_valid    (cdb_valid),
        .cdb_ready    (cdb_ready),
        .cdb_pc       (cdb_pc),
        .cdb_rob_idx  (cdb_rob_idx),
        .cdb_prd_new  (cdb_prd_new),
        .cdb_epoch    (cdb_epoch),
        .cdb_data     (cdb_data),
        .cdb_grant_id (cdb_grant_id),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [1:0] ep,
                           input logic [31:0] d, input logic [ROB_W-1:0] rob);
        src_valid[i]               = v;
        src_epoch[2*i +: 2]        = ep;
        src_data[32*i +: 32]       = d;
        src_pc[32*i +: 32]         = 32'h1000 + 32'(4 * i);
        src_rob_idx[ROB_W*i +: ROB_W] = rob;
        src_prd_new[PHYS_W*i +: PHYS_W] = PHYS_W'(i + 8);
    endtask

    initial begin
        rst = 1'b1;
        src_valid = '0; src_pc = '0; src_rob_idx = '0; src_prd_new = '0;
        src_epoch = '0; src_data = '0;
        cur_epoch = 2'd0; flush = 1'b0; cdb_ready = 1'b0;

        // Reset: outputs zero, ready held low even with valid requests
        step();
        src_valid = 4'hF;
        #1;
        chk("rst_ready", 32'(src_ready), 32'h0);
        step();
        chk("rst_valid", 32'(cdb_valid), 32'h0);
        chk("rst_drop", 32'(drop_cnt), 32'h0);
        chk("rst_gid", 32'(cdb_grant_id), 32'h0);
        chk("rst_data", cdb_data, 32'h0);
        src_valid = '0;
        rst = 1'b0;

        // Single source
        set_src(2, 1'b1, 2'd0, 32'h1234, 6'd2);
        cdb_ready = 1'b1;
        #1;
        chk("single_ready", 32'(src_ready), 32'h4);
        step();
        chk("single_valid", 32'(cdb_valid), 32'h1);
        chk("single_data", cdb_data, 32'h1234);
        chk("single_gid", 32'(cdb_grant_id), 32'h2);
        chk("single_pc", cdb_pc, 32'h1008);
        src_valid = '0;

        // Round robin from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            set_src(i, 1'b1, 2'd0, 32'hA0 + 32'(i), 6'(i));
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("rr_ready", 32'(src_ready), 32'(1 << (k % 4)));
            step();
            chk("rr_gid", 32'(cdb_grant_id), 32'(k % 4));
            chk("rr_data", cdb_data, 32'hA0 + 32'(k % 4));
        end

        // Park src3 in the buffer so the pointer wraps to 0
        src_valid = 4'b1000;
        step();
        chk("bp_setup_gid", 32'(cdb_grant_id), 32'h3);

        // Backpressure with full buffer
        cdb_ready = 1'b0;
        src_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", 32'(src_ready), 32'h0);
            step();
            chk("bp_valid", 32'(cdb_valid), 32'h1);
            chk("bp_gid", 32'(cdb_grant_id), 32'h3);
            chk("bp_data", cdb_data, 32'hA3);
        end
        cdb_ready = 1'b1;
        #1;
        chk("bp_rel_ready1", 32'(src_ready), 32'h2);
        step();
        chk("bp_rel_gid1", 32'(cdb_grant_id), 32'h1);
        src_valid = 4'b1000;
        #1;
        chk("bp_rel_ready3", 32'(src_ready), 32'h8);
        step();
        chk("bp_rel_gid3", 32'(cdb_grant_id), 32'h3);
        src_valid = '0;
        step();
        chk("bp_drain", 32'(cdb_valid), 32'h0);

        // Stale drop
        cur_epoch = 2'd1;
        set_src(0, 1'b1, 2'd0, 32'hB0, 6'd10);
        set_src(1, 1'b1, 2'd1, 32'hB1, 6'd11);
        #1;
        chk("stale_ready", 32'(src_ready), 32'h3);
        step();
        chk("stale_drop", 32'(drop_cnt), 32'h1);
        chk("stale_gid", 32'(cdb_grant_id), 32'h1);
        chk("stale_data", cdb_data, 32'hB1);
        src_valid = '0;
        step();

        // Flush kills the buffered entry
        set_src(2, 1'b1, 2'd1, 32'hC2, 6'd5);
        step();
        chk("fl_rob", 32'(cdb_rob_idx), 32'h5);
        src_valid = '0;
        set_src(0, 1'b1, 2'd1, 32'hC0, 6'd1);
        set_src(3, 1'b1, 2'd0, 32'hC3, 6'd3);
        flush = 1'b1;
        #1;
        chk("fl_valid", 32'(cdb_valid), 32'h0);
        chk("fl_ready", 32'(src_ready), 32'h0);
        step();
        flush = 1'b0;
        src_valid = '0;
        #1;
        chk("fl_after_valid", 32'(cdb_valid), 32'h0);
        chk("fl_after_drop", 32'(drop_cnt), 32'h1);
        for (int i = 0; i < NUM_SRC; i++)
            set_src(i, 1'b1, 2'd1, 32'hD0 + 32'(i), 6'(i));
        #1;
        chk("fl_rr_ready", 32'(src_ready), 32'h8);
        step();
        chk("fl_rr_gid", 32'(cdb_grant_id), 32'h3);
        src_valid = '0;

        // Reset mid-operation with a full buffer
        cdb_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid", 32'(cdb_valid), 32'h0);
        chk("mr_drop", 32'(drop_cnt), 32'h0);
        chk("mr_gid", 32'(cdb_grant_id), 32'h0);
        src_valid = 4'hF;
        #1;
        chk("mr_ready", 32'(src_ready), 32'h1);
        step();
        chk("mr_first_gid", 32'(cdb_grant_id), 32'h0);
        chk("mr_first_data", cdb_data, 32'hD0);

        // Drop counter saturation: 16383 cycles x 4 stale = 0xFFFC
        cdb_ready = 1'b1;
        src_epoch = '0;
        src_valid = 4'hF;
        #1;
        chk("sat_ready", 32'(src_ready), 32'hF);
        for (int k = 0; k < 16383; k++)
            step();
        chk("sat_fffc", 32'(drop_cnt), 32'hFFFC);
        src_valid = 4'b0011;
        step();
        chk("sat_fffe", 32'(drop_cnt), 32'hFFFE);
        step();
        chk("sat_ffff", 32'(drop_cnt), 32'hFFFF);
        step();
        chk("sat_hold", 32'(drop_cnt), 32'hFFFF);
        chk("sat_valid", 32'(cdb_valid), 32'h0);
        src_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
